// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: turns the received byte stream into make/break
// events, tracks the held state of the Mandelbrot navigation keys, and flags
// Esc presses and complete Pause sequences.
module ps2_key_decoder #(
  parameter int CLK_FREQ          = 50_000_000,
  parameter int PREFIX_TIMEOUT_US = 2000,
  parameter bit SUPPRESS_REPEAT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_new,
  input  logic [7:0] code_in,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] keys_held,
  output logic       view_reset,
  output logic       pause_evt
);

  localparam int TIMEOUT = CLK_FREQ / 1_000_000 * PREFIX_TIMEOUT_US;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       key_valid_q, key_ext_q, key_break_q, view_reset_q, pause_evt_q;
  logic [7:0] key_code_q, keys_held_q, held_d;

  logic       evt, evtExt, evtBreak, pauseHit, emit;
  logic       mapHit;
  logic [2:0] mapIdx;

  // Returns {hit, bit index} of a navigation key in the held-key bitmap.
  function automatic logic [3:0] keyIndex(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    case ({ext, code})
      9'h175:  r = 4'b1000;
      9'h172:  r = 4'b1001;
      9'h16B:  r = 4'b1010;
      9'h174:  r = 4'b1011;
      9'h079:  r = 4'b1100;
      9'h07B:  r = 4'b1101;
      9'h043:  r = 4'b1110;
      9'h042:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Keyboard housekeeping bytes that carry no key information.
  function automatic logic isIgnored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hEE) || (code == 8'hFA) ||
           (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

  // E0 12 / E0 59 are the fake-shift bytes some keyboards wrap around extended keys.
  function automatic logic isFakeShift(input logic [7:0] code);
    return (code == 8'h12) || (code == 8'h59);
  endfunction

  // Prefix tracking, Pause skipping and the prefix timeout; a byte arriving in
  // the expiry cycle wins over the timeout.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    cnt_d    = cnt_q;
    evt      = 1'b0;
    evtExt   = 1'b0;
    evtBreak = 1'b0;
    pauseHit = 1'b0;
    if (code_new) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (code_in == 8'hE0) begin
            state_d = S_EXT;
          end else if (code_in == 8'hF0) begin
            state_d = S_BRK;
          end else if (code_in == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!isIgnored(code_in)) begin
            evt = 1'b1;
          end
        end
        S_EXT: begin
          if (code_in == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            if (!isFakeShift(code_in)) begin
              evt    = 1'b1;
              evtExt = 1'b1;
            end
          end
        end
        S_BRK: begin
          state_d  = S_IDLE;
          evt      = 1'b1;
          evtBreak = 1'b1;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (!isFakeShift(code_in)) begin
            evt      = 1'b1;
            evtExt   = 1'b1;
            evtBreak = 1'b1;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d  = S_IDLE;
            pauseHit = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Decide whether a decoded event is reported and how it changes the held bitmap.
  always_comb begin
    {mapHit, mapIdx} = keyIndex(code_in, evtExt);
    held_d = keys_held_q;
    emit   = 1'b0;
    if (evt) begin
      emit = !(SUPPRESS_REPEAT && !evtBreak && mapHit && keys_held_q[mapIdx]);
      if (mapHit) begin
        held_d[mapIdx] = !evtBreak;
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered event outputs; the event fields hold until the next reported event.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      keys_held_q  <= 8'h00;
      view_reset_q <= 1'b0;
      pause_evt_q  <= 1'b0;
    end else begin
      key_valid_q  <= emit;
      keys_held_q  <= held_d;
      view_reset_q <= emit && !evtBreak && !evtExt && (code_in == 8'h76);
      pause_evt_q  <= pauseHit;
      if (emit) begin
        key_code_q  <= code_in;
        key_ext_q   <= evtExt;
        key_break_q <= evtBreak;
      end
    end
  end

  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign keys_held  = keys_held_q;
  assign view_reset = view_reset_q;
  assign pause_evt  = pause_evt_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (repeat suppression on and off) share
// one byte stream and are checked every cycle against a sequence-level model.
module tb_ps2_key_decoder;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_new = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       checkEn = 1'b0;

  logic       dValid [2];
  logic [7:0] dCode  [2];
  logic       dExt   [2];
  logic       dBrk   [2];
  logic [7:0] dHeld  [2];
  logic       dView  [2];
  logic       dPause [2];

  int vectors = 0;
  int miscompares = 0;

  // 10 ns system clock.
  always #5 clk = ~clk;

  ps2_key_decoder #(.CLK_FREQ(1_000_000), .PREFIX_TIMEOUT_US(T), .SUPPRESS_REPEAT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .code_new(code_new), .code_in(code_in),
    .key_valid(dValid[0]), .key_code(dCode[0]), .key_ext(dExt[0]), .key_break(dBrk[0]),
    .keys_held(dHeld[0]), .view_reset(dView[0]), .pause_evt(dPause[0])
  );

  ps2_key_decoder #(.CLK_FREQ(1_000_000), .PREFIX_TIMEOUT_US(T), .SUPPRESS_REPEAT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .code_new(code_new), .code_in(code_in),
    .key_valid(dValid[1]), .key_code(dCode[1]), .key_ext(dExt[1]), .key_break(dBrk[1]),
    .keys_held(dHeld[1]), .view_reset(dView[1]), .pause_evt(dPause[1])
  );

  // ---------------- model ----------------
  logic [8:0] mapTab [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h079, 9'h07B, 9'h043, 9'h042};
  logic       suppress [2] = '{1'b1, 1'b0};

  logic [7:0] seqBuf [2][8];
  int         seqLen [2];
  int         gap    [2];
  logic       expValid [2];
  logic [7:0] expCode  [2];
  logic       expExt   [2];
  logic       expBrk   [2];
  logic [7:0] expHeld  [2];
  logic       expView  [2];
  logic       expPause [2];

  task automatic emitEvent(input int m, input logic [7:0] code, input logic ext, input logic brk);
    int idx;
    idx = -1;
    for (int i = 0; i < 8; i++) if (mapTab[i] == {ext, code}) idx = i;
    if (!(suppress[m] && !brk && idx >= 0 && expHeld[m][idx])) begin
      expValid[m] = 1'b1;
      expCode[m]  = code;
      expExt[m]   = ext;
      expBrk[m]   = brk;
      expView[m]  = !brk && !ext && (code == 8'h76);
    end
    if (idx >= 0) expHeld[m][idx] = !brk;
  endtask

  task automatic modelByte(input int m, input logic [7:0] b);
    logic [7:0] first;
    logic complete;
    logic ignored;
    ignored = (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) || (b == 8'hFE) ||
              (b == 8'h00) || (b == 8'hFF);
    if (!(seqLen[m] == 0 && ignored)) begin
      seqBuf[m][seqLen[m]] = b;
      seqLen[m]++;
      first = seqBuf[m][0];
      complete = 1'b1;
      if (first == 8'hE1) begin
        complete = (seqLen[m] == 8);
        if (complete) expPause[m] = 1'b1;
      end else if (seqLen[m] == 1) begin
        if (b == 8'hE0 || b == 8'hF0) complete = 1'b0;
        else emitEvent(m, b, 1'b0, 1'b0);
      end else if (seqLen[m] == 2) begin
        if (first == 8'hF0) emitEvent(m, b, 1'b0, 1'b1);
        else if (b == 8'hF0) complete = 1'b0;
        else if (b != 8'h12 && b != 8'h59) emitEvent(m, b, 1'b1, 1'b0);
      end else begin
        if (b != 8'h12 && b != 8'h59) emitEvent(m, b, 1'b1, 1'b1);
      end
      if (complete) seqLen[m] = 0;
    end
  endtask

  // Advance the model once per clock edge from the same inputs the DUTs see.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      expValid[m] = 1'b0;
      expView[m]  = 1'b0;
      expPause[m] = 1'b0;
      if (reset) begin
        seqLen[m]  = 0;
        gap[m]     = 0;
        expCode[m] = 8'h00;
        expExt[m]  = 1'b0;
        expBrk[m]  = 1'b0;
        expHeld[m] = 8'h00;
      end else if (code_new) begin
        gap[m] = 0;
        modelByte(m, code_in);
      end else if (seqLen[m] != 0) begin
        gap[m]++;
        if (gap[m] == T) begin
          seqLen[m] = 0;
          gap[m]    = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("dut%0d.key_valid", m),  {7'b0, dValid[m]}, {7'b0, expValid[m]});
        checkOutput($sformatf("dut%0d.key_code", m),   dCode[m], expCode[m]);
        checkOutput($sformatf("dut%0d.key_ext", m),    {7'b0, dExt[m]}, {7'b0, expExt[m]});
        checkOutput($sformatf("dut%0d.key_break", m),  {7'b0, dBrk[m]}, {7'b0, expBrk[m]});
        checkOutput($sformatf("dut%0d.keys_held", m),  dHeld[m], expHeld[m]);
        checkOutput($sformatf("dut%0d.view_reset", m), {7'b0, dView[m]}, {7'b0, expView[m]});
        checkOutput($sformatf("dut%0d.pause_evt", m),  {7'b0, dPause[m]}, {7'b0, expPause[m]});
      end
    end
  end

  // One byte strobe, then an optional number of idle cycles.
  task automatic applyStimulus(input logic [7:0] b, input int idle);
    @(negedge clk);
    code_in  = b;
    code_new = 1'b1;
    @(negedge clk);
    code_new = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  logic [7:0] pauseSeq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  // Directed scenarios with hand-computed spot checks.
  initial begin
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset.key_valid", {7'b0, dValid[0]}, 8'h00);
    checkOutput("reset.keys_held", dHeld[0], 8'h00);
    reset = 1'b0;

    applyStimulus(8'h1D, 0);
    checkOutput("t1.make_valid", {7'b0, dValid[0]}, 8'h01);
    checkOutput("t1.make_code", dCode[0], 8'h1D);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h1D, 0);
    checkOutput("t1.break_flag", {7'b0, dBrk[0]}, 8'h01);
    checkOutput("t1.held", dHeld[0], 8'h00);

    applyStimulus(8'hE0, 0);
    applyStimulus(8'h75, 0);
    checkOutput("t2.make_ext", {7'b0, dExt[0]}, 8'h01);
    checkOutput("t2.held", dHeld[0], 8'h01);
    applyStimulus(8'hE0, 0);
    applyStimulus(8'h75, 0);
    checkOutput("t2.repeat_suppressed", {7'b0, dValid[0]}, 8'h00);
    checkOutput("t2.repeat_emitted", {7'b0, dValid[1]}, 8'h01);
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h75, 0);
    checkOutput("t2.break_valid", {7'b0, dValid[0]}, 8'h01);
    checkOutput("t2.break_held", dHeld[0], 8'h00);

    for (int i = 0; i < 8; i++) applyStimulus(pauseSeq[i], 0);
    checkOutput("t3.pause", {7'b0, dPause[0]}, 8'h01);
    checkOutput("t3.no_key", {7'b0, dValid[0]}, 8'h00);
    applyStimulus(8'h79, 0);
    checkOutput("t3.zoom_held", dHeld[0], 8'h10);

    applyStimulus(8'hE0, T - 1);
    applyStimulus(8'h6B, 0);
    checkOutput("t4.valid", {7'b0, dValid[0]}, 8'h01);
    checkOutput("t4.ext", {7'b0, dExt[0]}, 8'h00);
    checkOutput("t4.held", dHeld[0], 8'h10);

    applyStimulus(8'hF0, T - 2);
    applyStimulus(8'h43, 0);
    checkOutput("t5.expiry_break", {7'b0, dBrk[0]}, 8'h01);
    checkOutput("t5.expiry_code", dCode[0], 8'h43);
    applyStimulus(8'hE0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5.rst_code", dCode[0], 8'h00);
    checkOutput("t5.rst_held", dHeld[0], 8'h00);
    checkOutput("t5.rst_valid", {7'b0, dValid[0]}, 8'h00);
    reset = 1'b0;
    applyStimulus(8'h74, 0);
    checkOutput("t5.after_rst_ext", {7'b0, dExt[0]}, 8'h00);
    checkOutput("t5.after_rst_code", dCode[0], 8'h74);

    applyStimulus(8'h76, 0);
    checkOutput("t6.esc_view", {7'b0, dView[0]}, 8'h01);
    applyStimulus(8'hF0, 0);
    applyStimulus(8'h76, 0);
    checkOutput("t6.esc_break_valid", {7'b0, dValid[0]}, 8'h01);
    checkOutput("t6.esc_break_view", {7'b0, dView[0]}, 8'h00);
    applyStimulus(8'hAA, 0);
    checkOutput("t6.aa_valid", {7'b0, dValid[0]}, 8'h00);

    repeat (4) @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
